deco_seq_n: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder. Successor to the fixed 3-to-8 gate-level decoder.
- Adds three things the combinational part lacks: a registered direct-decode mode, an auto-scan mode and a timed one-shot pulse mode.
- Drives one-hot selects for display digit scanning, row strobes and chip selects from a single clock domain.

---
 rtl/deco_seq_n_pkg.sv | 30 +++
 rtl/deco_seq_n_if.sv | 33 +++
 rtl/deco_seq_n_dwell_timer.sv | 33 +++
 rtl/deco_seq_n.sv | 115 +++++++++++
 tb/tb_deco_seq_n.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/deco_seq_n_pkg.sv
// deco_seq_pkg: shared definitions for the deco_seq_n decoder.
//   - MODE_* : encodings of the 2-bit mode input.
//   - state_t: top-level behaviour FSM, also exported on the debug port.
//   - onehot : N-aware one-hot helper (bit i of a 2^n-bit field, max n=6).
package deco_seq_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // ST_HALT covers every cycle in which y is forced to zero: reset, en=0,
  // the mode-change cycle, reserved mode and an idle PULSE.
  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_PULSE  = 2'd3
  } state_t;

  // Returns a 64-bit field with bit i set, provided i addresses one of the
  // 2^n outputs; callers truncate to their own 2^n width.
  function automatic logic [63:0] onehot(input int unsigned n, input logic [5:0] i);
    logic [63:0] r;
    r = '0;
    if ({26'd0, i} < (32'd1 << n)) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/deco_seq_n_if.sv
// deco_seq_n_if: bundle of the decoder's control inputs and registered outputs.
//   Controls : d (binary select), en, mode, dwell, start
//   Outputs  : y (one-hot or zero), idx, busy, wrap
//   master   : the side that drives controls and observes outputs.
//   slave    : the decoder itself.
// There is no valid/ready handshake on this bus: every control is a plain
// level sampled on each rising clk edge, and every output is a register
// updated on that same edge (start in particular is level-sampled, not an
// edge or a request that waits for acceptance).
interface deco_seq_n_if #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
);
  logic [N-1:0]        d;
  logic                en;
  logic [1:0]          mode;
  logic [DWELL_W-1:0]  dwell;
  logic                start;
  logic [(1<<N)-1:0]   y;
  logic [N-1:0]        idx;
  logic                busy;
  logic                wrap;

  modport master (
    output d, en, mode, dwell, start,
    input  y, idx, busy, wrap
  );

  modport slave (
    input  d, en, mode, dwell, start,
    output y, idx, busy, wrap
  );
endinterface

// File: rtl/deco_seq_n_dwell_timer.sv
// dwell_timer: DWELL_W-bit dwell counter shared by SCAN stepping and PULSE
// length timing.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force cnt to zero (takes priority over enable)
//   enable   : advance cnt; on terminal it returns to zero instead
//   dwell    : terminal value, compared live every cycle
//   terminal : cnt == dwell
// If dwell is lowered below the running count, cnt keeps counting up,
// rolls over at 2^DWELL_W-1 and meets dwell on the way back up.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  output logic               terminal
);

  logic [DWELL_W-1:0] cnt;

  assign terminal = (cnt == dwell);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= terminal ? '0 : cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/deco_seq_n.sv
// deco_seq_n: registered N-to-2^N one-hot decoder with DIRECT, SCAN and
// timed PULSE modes.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : deco_seq_n_if.slave (d, en, mode, dwell, start -> y, idx,
//               busy, wrap)
//   dbg_state : current behaviour FSM state
// Priority each edge: rst, then a mode change (one all-zero cycle, counter
// cleared, idx held), then en=0 (all-zero, idx and counter held), then the
// selected mode. y is always zero or onehot(idx) because both are loaded
// from the same idx_n.
module deco_seq_n
  import deco_seq_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  deco_seq_n_if.slave    bus,
  output state_t         dbg_state
);

  localparam int W = 1 << N;

  state_t          state, state_n;
  logic [1:0]      prev_mode;
  logic [N-1:0]    idx, idx_n;
  logic [W-1:0]    y, y_n;
  logic            wrap, wrap_n;
  logic            y_on;
  logic            tmr_clear, tmr_en, tmr_term;
  logic            mode_changed;

  assign mode_changed = (bus.mode != prev_mode);

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .enable   (tmr_en),
    .dwell    (bus.dwell),
    .terminal (tmr_term)
  );

  always_comb begin
    state_n   = ST_HALT;
    idx_n     = idx;
    y_on      = 1'b0;
    wrap_n    = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    if (mode_changed) begin
      tmr_clear = 1'b1;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_DIRECT: begin
          state_n   = ST_DIRECT;
          idx_n     = bus.d;
          y_on      = 1'b1;
          tmr_clear = 1'b1;
        end
        MODE_SCAN: begin
          state_n = ST_SCAN;
          y_on    = 1'b1;
          tmr_en  = 1'b1;
          if (tmr_term) begin
            idx_n  = idx + N'(1);
            wrap_n = (idx == {N{1'b1}});
          end
        end
        MODE_PULSE: begin
          if (state == ST_PULSE) begin
            // Timer self-clears on terminal, ready for the next launch.
            tmr_en = 1'b1;
            if (!tmr_term) begin
              state_n = ST_PULSE;
              y_on    = 1'b1;
            end
          end else if (bus.start) begin
            state_n   = ST_PULSE;
            idx_n     = bus.d;
            y_on      = 1'b1;
            tmr_clear = 1'b1;
          end
        end
        default: ;  // reserved: all-zero, counters hold
      endcase
    end
    y_n = y_on ? W'(onehot(unsigned'(N), 6'(idx_n))) : '0;
  end

  always_ff @(posedge clk) begin
    // prev_mode follows mode on every edge, reset included, so a mode that
    // is already stable when reset releases does not cost a dead cycle.
    prev_mode <= bus.mode;
    if (rst) begin
      state <= ST_HALT;
      idx   <= '0;
      y     <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      y     <= y_n;
      wrap  <= wrap_n;
    end
  end

  assign bus.y     = y;
  assign bus.idx   = idx;
  assign bus.busy  = (state == ST_PULSE);
  assign bus.wrap  = wrap;
  assign dbg_state = state;

endmodule

// File: tb/tb_deco_seq_n.sv
// tb_deco_seq_n: three decoder instances (N=3, 1, 6) share one stimulus
// stream. Each instance has a spec-level model that pushes expected outputs
// into exp_q at every posedge and a compare process that pops them at the
// negedge. Directed literal checks pin the test-plan scenarios.
module tb_deco_seq_n;
  import deco_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst;
  logic [5:0]  s_d;
  logic        s_en;
  logic [1:0]  s_mode;
  logic [7:0]  s_dwell;
  logic        s_start;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- DUTs, models, scoreboards ----------------
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int NV = (g == 0) ? 3 : ((g == 1) ? 1 : 6);
    localparam int WV = 1 << NV;

    deco_seq_n_if #(.N(NV), .DWELL_W(8)) bus ();
    state_t dbg_state;

    assign bus.d     = s_d[NV-1:0];
    assign bus.en    = s_en;
    assign bus.mode  = s_mode;
    assign bus.dwell = s_dwell;
    assign bus.start = s_start;

    deco_seq_n #(.N(NV), .DWELL_W(8)) dut (
      .clk       (clk),
      .rst       (s_rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
    );

    logic [63:0] y_w;
    logic [7:0]  idx_w;
    logic        busy_w, wrap_w;
    assign y_w    = 64'(bus.y);
    assign idx_w  = 8'(bus.idx);
    assign busy_w = bus.busy;
    assign wrap_w = bus.wrap;

    // Behavioural model: outputs derived directly from the mode rules.
    logic [WV-1:0]     m_y;
    logic [NV-1:0]     m_idx;
    logic              m_busy, m_wrap;
    logic [7:0]        m_cnt;
    logic [1:0]        m_prev;
    bit                m_valid = 1'b0;
    logic [WV+NV+1:0]  exp_q[$];

    always @(posedge clk) begin : model
      logic changed;
      changed = (s_mode != m_prev);
      m_prev  = s_mode;
      m_wrap  = 1'b0;
      if (s_rst) begin
        m_y = '0; m_idx = '0; m_busy = 1'b0; m_cnt = '0;
        m_valid = 1'b1;
      end else if (changed) begin
        m_y = '0; m_busy = 1'b0; m_cnt = '0;
      end else if (!s_en) begin
        m_y = '0; m_busy = 1'b0;
      end else begin
        case (s_mode)
          MODE_DIRECT: begin
            m_idx = s_d[NV-1:0];
            m_y = WV'(1) << m_idx;
            m_cnt = '0; m_busy = 1'b0;
          end
          MODE_SCAN: begin
            if (m_cnt == s_dwell) begin
              m_cnt = '0;
              m_idx = NV'((int'(m_idx) + 1) % WV);
              m_wrap = (m_idx == 0);
            end else begin
              m_cnt = m_cnt + 8'd1;
            end
            m_y = WV'(1) << m_idx;
            m_busy = 1'b0;
          end
          MODE_PULSE: begin
            if (m_busy) begin
              if (m_cnt == s_dwell) begin
                m_y = '0; m_busy = 1'b0; m_cnt = '0;
              end else begin
                m_cnt = m_cnt + 8'd1;
                m_y = WV'(1) << m_idx;
              end
            end else if (s_start) begin
              m_idx = s_d[NV-1:0];
              m_y = WV'(1) << m_idx;
              m_busy = 1'b1; m_cnt = '0;
            end else begin
              m_y = '0;
            end
          end
          default: begin
            m_y = '0; m_busy = 1'b0;
          end
        endcase
      end
      if (m_valid) exp_q.push_back({m_y, m_idx, m_busy, m_wrap});
    end

    always @(negedge clk) begin : compare
      logic [WV+NV+1:0] exp_v;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_vec++;
        if ({bus.y, bus.idx, bus.busy, bus.wrap} !== exp_v) begin
          n_err++;
          $display("FAIL model_n%0d t=%0t got y=%0h idx=%0d busy=%b wrap=%b, exp y=%0h idx=%0d busy=%b wrap=%b",
                   NV, $time, bus.y, bus.idx, bus.busy, bus.wrap,
                   exp_v[WV+NV+1:NV+2], exp_v[NV+1:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_rst = 1'b1; s_en = 1'b0; s_mode = MODE_DIRECT; s_d = '0;
    s_dwell = '0; s_start = 1'b0;
    repeat (3) tick();
    check("rst_y",    g_inst[0].y_w,    64'h0);
    check("rst_idx",  g_inst[0].idx_w,  64'h0);
    check("rst_busy", g_inst[0].busy_w, 64'h0);
    check("rst_wrap", g_inst[0].wrap_w, 64'h0);

    // DIRECT
    s_rst = 1'b0; s_en = 1'b1; s_d = 6'd5; tick();
    check("direct_d5_y",   g_inst[0].y_w,   64'h20);
    check("direct_d5_idx", g_inst[0].idx_w, 64'd5);
    s_d = 6'd0; tick();
    check("direct_d0_y", g_inst[0].y_w, 64'h01);
    s_en = 1'b0; s_d = 6'd3; tick();
    check("en0_y",   g_inst[0].y_w,   64'h0);
    check("en0_idx", g_inst[0].idx_w, 64'd0);

    // SCAN dwell=2: each idx held 3 cycles, wrap on the 24th scan cycle
    s_en = 1'b1; s_mode = MODE_SCAN; s_dwell = 8'd2; s_d = 6'd0; tick();
    check("scan_chg_y", g_inst[0].y_w, 64'h0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("scan_idx",  g_inst[0].idx_w,  64'((k / 3) % 8));
      check("scan_y",    g_inst[0].y_w,    64'd1 << ((k / 3) % 8));
      check("scan_wrap", g_inst[0].wrap_w, 64'(k == 24));
    end

    // PULSE dwell=3, d=6: four high cycles, start during busy ignored
    s_mode = MODE_PULSE; s_dwell = 8'd3; s_start = 1'b0; tick();
    check("pulse_chg_y", g_inst[0].y_w, 64'h0);
    s_start = 1'b1; s_d = 6'd6; tick();
    check("pulse_c1_y",    g_inst[0].y_w,    64'h40);
    check("pulse_c1_busy", g_inst[0].busy_w, 64'h1);
    s_start = 1'b0; s_d = 6'd1; tick();
    check("pulse_c2_y", g_inst[0].y_w, 64'h40);
    s_start = 1'b1; tick();
    check("pulse_c3_y",   g_inst[0].y_w,   64'h40);
    check("pulse_c3_idx", g_inst[0].idx_w, 64'd6);
    s_start = 1'b0; tick();
    check("pulse_c4_y",    g_inst[0].y_w,    64'h40);
    check("pulse_c4_busy", g_inst[0].busy_w, 64'h1);
    tick();
    check("pulse_end_y",    g_inst[0].y_w,    64'h0);
    check("pulse_end_busy", g_inst[0].busy_w, 64'h0);
    tick();
    check("pulse_noretrig_y", g_inst[0].y_w, 64'h0);

    // PULSE start held, dwell=0: 1 high, 1 low, repeating
    s_dwell = 8'd0; s_d = 6'd2; s_start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("pulse_held_y",    g_inst[0].y_w,    (k % 2 == 0) ? 64'h04 : 64'h0);
      check("pulse_held_busy", g_inst[0].busy_w, 64'((k % 2) == 0));
    end
    s_start = 1'b0;

    // reset mid-pulse
    s_dwell = 8'd5; s_d = 6'd3; s_start = 1'b1; tick();
    check("abort_rst_pre_y", g_inst[0].y_w, 64'h08);
    s_start = 1'b0; tick();
    s_rst = 1'b1; tick();
    check("abort_rst_y",    g_inst[0].y_w,    64'h0);
    check("abort_rst_busy", g_inst[0].busy_w, 64'h0);
    check("abort_rst_idx",  g_inst[0].idx_w,  64'h0);
    s_rst = 1'b0;

    // mode change mid-pulse, then scanning resumes from held idx
    s_d = 6'd4; s_start = 1'b1; tick();
    check("abort_mode_pre_busy", g_inst[0].busy_w, 64'h1);
    s_start = 1'b0; s_mode = MODE_SCAN; s_dwell = 8'd0; tick();
    check("abort_mode_y",    g_inst[0].y_w,    64'h0);
    check("abort_mode_busy", g_inst[0].busy_w, 64'h0);
    check("abort_mode_idx",  g_inst[0].idx_w,  64'd4);
    tick();
    check("abort_mode_resume_idx", g_inst[0].idx_w, 64'd5);
    check("abort_mode_resume_y",   g_inst[0].y_w,   64'h20);

    // N=1 / N=6 sweep: SCAN dwell=0 wraps after 2 and 64 cycles
    s_mode = MODE_DIRECT; s_d = 6'd0; tick(); tick();
    check("n1_direct0_y", g_inst[1].y_w, 64'h1);
    check("n6_direct0_y", g_inst[2].y_w, 64'h1);
    s_mode = MODE_SCAN; s_dwell = 8'd0; tick();
    for (int k = 1; k <= 64; k++) begin
      tick();
      check("n1_scan_wrap", g_inst[1].wrap_w, 64'((k % 2) == 0));
      check("n1_scan_y",    g_inst[1].y_w,    64'd1 << (k % 2));
      check("n6_scan_wrap", g_inst[2].wrap_w, 64'(k == 64));
      check("n6_scan_idx",  g_inst[2].idx_w,  64'(k % 64));
    end
    s_mode = MODE_DIRECT; s_d = 6'd63; tick(); tick();
    check("n6_direct63_y", g_inst[2].y_w, 64'h8000_0000_0000_0000);
    check("n1_direct1_y",  g_inst[1].y_w, 64'h2);

    // randomized phase, checked by the per-instance models
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) s_mode = 2'($urandom_range(0, 3));
      s_en    = ($urandom_range(0, 15) != 0);
      s_start = ($urandom_range(0, 2) == 0);
      s_d     = 6'($urandom);
      if ($urandom_range(0, 19) == 0) s_dwell = 8'($urandom_range(0, 6));
      else if ($urandom_range(0, 299) == 0) s_dwell = 8'($urandom_range(250, 255));
      s_rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    s_rst = 1'b0; s_en = 1'b0; s_start = 1'b0;
    repeat (3) tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
